// File: rtl/maze_pkg.sv
// Shared maze definitions used by the maze memory and the solver.
package maze_pkg;
  localparam int MAZE_W = 6;
  localparam int MAZE_N = 1 << MAZE_W;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SERVE} maze_state_e;
endpackage

// File: rtl/maze_bitmap.sv
// N x N bit store: one row-wide write, one single-bit set, bulk clear, one registered single-bit read.
module maze_bitmap #(
  parameter int   COORD_W = 6,
  parameter logic RD_INIT = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      wr_en,
  input  logic [COORD_W-1:0]        wr_row,
  input  logic [(1<<COORD_W)-1:0]   wr_bits,
  input  logic                      set_en,
  input  logic [COORD_W-1:0]        set_row,
  input  logic [COORD_W-1:0]        set_col,
  output logic                      set_new,
  input  logic                      rd_en,
  input  logic [COORD_W-1:0]        rd_row,
  input  logic [COORD_W-1:0]        rd_col,
  output logic                      rd_bit
);
  localparam int N = 1 << COORD_W;

  logic [N-1:0] mem [N];

  // set_new flags a set that lands on a bit that was still clear
  assign set_new = set_en & ~mem[set_row][set_col];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else begin
      if (wr_en)  mem[wr_row] <= wr_bits;
      if (set_en) mem[set_row][set_col] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        rd_bit <= RD_INIT;
    else if (rd_en) rd_bit <= mem[rd_row][rd_col];
  end
endmodule

// File: rtl/maze_mem.sv
// Maze wall memory answering solver reads with one-cycle latency.
// Optional visit tracking is enabled by defining MAZE_MEM_TRACE_EN.
module maze_mem
  import maze_pkg::*;
#(
  parameter int maze_width = MAZE_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_start,
  input  logic                      load_valid,
  input  logic [(1<<maze_width)-1:0] load_row_bits,
  output logic                      load_ready,
  output logic                      loaded,
  input  logic [maze_width-1:0]     row,
  input  logic [maze_width-1:0]     col,
  input  logic                      maze_oe,
  input  logic                      maze_we,
  output logic                      maze_in
`ifdef MAZE_MEM_TRACE_EN
  ,
  output logic [2*maze_width:0]     visit_count
`endif
);
  localparam int N = 1 << maze_width;

  maze_state_e             state;
  logic [maze_width-1:0]   load_cnt;
  logic                    in_load;
  logic                    in_serve;
  logic                    wall_wr_en;
  logic                    wall_set_unused;

  assign in_load    = (state == ST_LOAD);
  assign in_serve   = (state == ST_SERVE);
  // a restart in LOAD takes precedence over a beat arriving the same cycle
  assign wall_wr_en = in_load & load_valid & ~load_start;

  maze_bitmap #(.COORD_W(maze_width), .RD_INIT(1'b1)) u_wall (
    .clk     (clk),
    .rst     (rst),
    .clr     (1'b0),
    .wr_en   (wall_wr_en),
    .wr_row  (load_cnt),
    .wr_bits (load_row_bits),
    .set_en  (1'b0),
    .set_row ('0),
    .set_col ('0),
    .set_new (wall_set_unused),
    .rd_en   (in_serve & maze_oe),
    .rd_row  (row),
    .rd_col  (col),
    .rd_bit  (maze_in)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      load_cnt   <= '0;
      load_ready <= 1'b0;
      loaded     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_start) begin
            state      <= ST_LOAD;
            load_cnt   <= '0;
            load_ready <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (load_start) begin
            load_cnt <= '0;
          end else if (load_valid) begin
            load_cnt <= load_cnt + maze_width'(1);
            if (&load_cnt) begin
              state      <= ST_SERVE;
              load_ready <= 1'b0;
              loaded     <= 1'b1;
            end
          end
        end
        ST_SERVE: begin
          if (load_start) begin
            state      <= ST_LOAD;
            load_cnt   <= '0;
            load_ready <= 1'b1;
            loaded     <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          load_ready <= 1'b0;
          loaded     <= 1'b0;
        end
      endcase
    end
  end

`ifdef MAZE_MEM_TRACE_EN
  localparam logic [2*maze_width:0] VISIT_MAX = (2*maze_width+1)'(N * N);

  logic visit_clr;
  logic visit_new;
  logic visit_rd_unused;

  assign visit_clr = rst | (in_serve & load_start);

  maze_bitmap #(.COORD_W(maze_width), .RD_INIT(1'b0)) u_visit (
    .clk     (clk),
    .rst     (rst),
    .clr     (visit_clr),
    .wr_en   (1'b0),
    .wr_row  ('0),
    .wr_bits ('0),
    .set_en  (in_serve & maze_we & ~load_start),
    .set_row (row),
    .set_col (col),
    .set_new (visit_new),
    .rd_en   (1'b0),
    .rd_row  ('0),
    .rd_col  ('0),
    .rd_bit  (visit_rd_unused)
  );

  always_ff @(posedge clk) begin
    if (visit_clr)                                 visit_count <= '0;
    else if (visit_new && visit_count != VISIT_MAX) visit_count <= visit_count + 1'b1;
  end
`else
  logic we_unused;
  assign we_unused = maze_we;
`endif
endmodule

// File: tb/tb_maze_mem.sv
// Self-checking bench for maze_mem against a cycle-level behavioural model.
module tb_maze_mem;
  import maze_pkg::*;

  localparam int W = MAZE_W;
  localparam int N = 1 << W;
`ifdef MAZE_MEM_TRACE_EN
  localparam bit TRACE = 1'b1;
`else
  localparam bit TRACE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load_start = 1'b0;
  logic         load_valid = 1'b0;
  logic [N-1:0] load_row_bits = '0;
  logic         load_ready;
  logic         loaded;
  logic [W-1:0] row = '0;
  logic [W-1:0] col = '0;
  logic         maze_oe = 1'b0;
  logic         maze_we = 1'b0;
  logic         maze_in;
`ifdef MAZE_MEM_TRACE_EN
  logic [2*W:0] visit_count;
`endif

  maze_mem #(.maze_width(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .load_start    (load_start),
    .load_valid    (load_valid),
    .load_row_bits (load_row_bits),
    .load_ready    (load_ready),
    .loaded        (loaded),
    .row           (row),
    .col           (col),
    .maze_oe       (maze_oe),
    .maze_we       (maze_we),
    .maze_in       (maze_in)
`ifdef MAZE_MEM_TRACE_EN
    ,
    .visit_count   (visit_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: phase flags, rows received, wall array, visited set.
  logic [N-1:0] m_wall [N];
  bit           m_loading = 1'b0;
  bit           m_loaded  = 1'b0;
  int           m_rows    = 0;
  logic         m_in      = 1'b1;
  bit           m_vis [N][N];
  int           m_vcount  = 0;

  function automatic void clear_vis();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) m_vis[r][c] = 1'b0;
    m_vcount = 0;
  endfunction

  function automatic int obs_vcount();
`ifdef MAZE_MEM_TRACE_EN
    return int'(visit_count);
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_loading = 1'b0; m_loaded = 1'b0; m_rows = 0; m_in = 1'b1;
      clear_vis();
    end else if (m_loaded) begin
      if (maze_oe) m_in = m_wall[row][col];
      if (load_start) begin
        m_loaded = 1'b0; m_loading = 1'b1; m_rows = 0;
        clear_vis();
      end else if (maze_we && TRACE && !m_vis[row][col]) begin
        m_vis[row][col] = 1'b1;
        if (m_vcount < N * N) m_vcount++;
      end
    end else if (m_loading) begin
      if (load_start) m_rows = 0;
      else if (load_valid) begin
        m_wall[m_rows] = load_row_bits;
        m_rows++;
        if (m_rows == N) begin m_loading = 1'b0; m_loaded = 1'b1; end
      end
    end else if (load_start) begin
      m_loading = 1'b1; m_rows = 0;
    end
    #1;
  endtask

  function automatic logic [N-1:0] diag_row(input int r);
    logic [N-1:0] one;
    one = 1;
    return one << (r % 64);
  endfunction

  // Start a load and feed all rows back to back; mode 0 = diagonal, 1 = random.
  task automatic full_load(input int mode);
    load_start = 1'b1; tick(); load_start = 1'b0;
    load_valid = 1'b1;
    for (int r = 0; r < N; r++) begin
      load_row_bits = (mode == 0) ? diag_row(r) : {$urandom, $urandom};
      tick();
    end
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL reset_load_ready got %b want 0", load_ready); end
    checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL reset_loaded got %b want 0", loaded); end
    checks++; if (maze_in !== 1'b1) begin errors++; $display("FAIL reset_maze_in got %b want 1", maze_in); end
    checks++; if (obs_vcount() != 0) begin errors++; $display("FAIL reset_visit_count got %0d want 0", obs_vcount()); end
    maze_oe = 1'b1; maze_we = 1'b1; row = 3; col = 4; tick(); tick();
    maze_oe = 1'b0; maze_we = 1'b0;
    checks++; if (maze_in !== m_in) begin errors++; $display("FAIL idle_oe_ignored got %b want %b", maze_in, m_in); end
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL idle_load_ready got %b want 0", load_ready); end
  endtask

  task automatic test_load_timing();
    int rise_beat;
    rise_beat = -1;
    load_start = 1'b1; tick(); load_start = 1'b0;
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL load_ready_rise got %b want 1", load_ready); end
    load_valid = 1'b1;
    maze_oe = 1'b1; maze_we = 1'b1;
    for (int r = 0; r < N; r++) begin
      load_row_bits = diag_row(r);
      row = W'($urandom); col = W'($urandom);
      if (r == N - 1) begin maze_oe = 1'b0; maze_we = 1'b0; end
      tick();
      if (loaded === 1'b1 && rise_beat < 0) rise_beat = r + 1;
      checks++;
      if (loaded !== m_loaded || load_ready !== m_loading) begin
        errors++;
        $display("FAIL load_beat_%0d loaded/ready got %b/%b want %b/%b", r, loaded, load_ready, m_loaded, m_loading);
      end
      checks++; if (maze_in !== m_in) begin errors++; $display("FAIL load_oe_ignored beat %0d got %b want %b", r, maze_in, m_in); end
    end
    load_valid = 1'b0;
    checks++; if (rise_beat != N) begin errors++; $display("FAIL loaded_rise_beat got %0d want %0d", rise_beat, N); end
    checks++; if (obs_vcount() != 0) begin errors++; $display("FAIL load_we_ignored got %0d want 0", obs_vcount()); end
  endtask

  task automatic test_reads();
    maze_oe = 1'b1; row = 5; col = 5; tick();
    checks++; if (maze_in !== 1'b1) begin errors++; $display("FAIL read_5_5 got %b want 1", maze_in); end
    row = 5; col = 6; tick();
    checks++; if (maze_in !== 1'b0) begin errors++; $display("FAIL read_5_6 got %b want 0", maze_in); end
    maze_oe = 1'b0; row = 9; col = 9;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (maze_in !== 1'b0) begin errors++; $display("FAIL hold_%0d got %b want 0", i, maze_in); end
    end
    maze_oe = 1'b1;
    for (int i = 0; i < 40; i++) begin
      row = W'($urandom); col = (i % 2 == 0) ? row : W'($urandom);
      tick();
      checks++; if (maze_in !== m_in) begin errors++; $display("FAIL rand_read (%0d,%0d) got %b want %b", row, col, maze_in, m_in); end
    end
    maze_oe = 1'b0;
  endtask

  task automatic test_oe_we_same();
    maze_oe = 1'b1; maze_we = 1'b1; row = 7; col = 7; tick();
    maze_we = 1'b0;
    checks++; if (maze_in !== 1'b1) begin errors++; $display("FAIL oe_we_7_7 got %b want 1", maze_in); end
    col = 8; tick();
    checks++; if (maze_in !== 1'b0) begin errors++; $display("FAIL read_7_8 got %b want 0", maze_in); end
    col = 7; tick();
    checks++; if (maze_in !== 1'b1) begin errors++; $display("FAIL reread_7_7 got %b want 1", maze_in); end
    checks++; if (obs_vcount() != m_vcount) begin errors++; $display("FAIL oe_we_count got %0d want %0d", obs_vcount(), m_vcount); end
    maze_oe = 1'b0;
  endtask

  task automatic test_trace();
    int pre;
    pre = m_vcount;
    maze_we = 1'b1;
    row = 1; col = 2; tick();
    row = 1; col = 2; tick();
    row = 3; col = 4; tick();
    maze_we = 1'b0;
    checks++; if (obs_vcount() != m_vcount || (TRACE && m_vcount != pre + 2)) begin errors++; $display("FAIL visit_count_marks got %0d want %0d", obs_vcount(), m_vcount); end
    load_start = 1'b1; tick(); load_start = 1'b0;
    checks++; if (obs_vcount() != 0) begin errors++; $display("FAIL visit_clear_on_start got %0d want 0", obs_vcount()); end
    checks++; if (load_ready !== 1'b1 || loaded !== 1'b0) begin errors++; $display("FAIL serve_restart ready/loaded got %b/%b want 1/0", load_ready, loaded); end
    load_valid = 1'b1;
    for (int r = 0; r < N; r++) begin load_row_bits = {$urandom, $urandom}; tick(); end
    load_valid = 1'b0;
    maze_we = 1'b1;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin row = W'(r); col = W'(c); tick(); end
    for (int i = 0; i < 20; i++) begin row = W'($urandom); col = W'($urandom); tick(); end
    maze_we = 1'b0;
    checks++; if (obs_vcount() != m_vcount || (TRACE && m_vcount != N * N)) begin errors++; $display("FAIL visit_saturate got %0d want %0d", obs_vcount(), m_vcount); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 200; i++) begin
      maze_oe = 1'($urandom); maze_we = 1'($urandom);
      row = W'($urandom); col = W'($urandom);
      tick();
      checks++;
      if (maze_in !== m_in || obs_vcount() != m_vcount || loaded !== 1'b1) begin
        errors++;
        $display("FAIL b2b_%0d in/count/loaded got %b/%0d/%b want %b/%0d/1", i, maze_in, obs_vcount(), loaded, m_in, m_vcount);
      end
    end
    maze_oe = 1'b0; maze_we = 1'b0;
  endtask

  task automatic test_rst_mid_load();
    maze_oe = 1'b1; row = 2; col = 2; tick(); maze_oe = 1'b0;
    load_start = 1'b1; tick(); load_start = 1'b0;
    load_valid = 1'b1;
    for (int r = 0; r < 30; r++) begin load_row_bits = diag_row(r); tick(); end
    rst = 1'b1; tick(); rst = 1'b0; load_valid = 1'b0;
    checks++; if (maze_in !== 1'b1) begin errors++; $display("FAIL rst_mid_maze_in got %b want 1", maze_in); end
    checks++; if (load_ready !== 1'b0 || loaded !== 1'b0) begin errors++; $display("FAIL rst_mid ready/loaded got %b/%b want 0/0", load_ready, loaded); end
    checks++; if (obs_vcount() != 0) begin errors++; $display("FAIL rst_mid_visit got %0d want 0", obs_vcount()); end
    full_load(0);
    checks++; if (loaded !== 1'b1 || load_ready !== 1'b0) begin errors++; $display("FAIL reload ready/loaded got %b/%b want 0/1", load_ready, loaded); end
    maze_oe = 1'b1;
    for (int i = 0; i < 8; i++) begin
      row = W'($urandom); col = (i % 2 == 0) ? row : W'(row + 1);
      tick();
      checks++; if (maze_in !== m_in || maze_in !== ((i % 2 == 0) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL reload_read (%0d,%0d) got %b want %b", row, col, maze_in, m_in); end
    end
    maze_oe = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_timing();
    test_reads();
    test_oe_we_same();
    test_trace();
    test_back_to_back();
    test_rst_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/maze_mem.md
# maze_mem

Responder end of the maze access interface. Holds the maze wall bitmap and answers the solver's row/col reads on `maze_oe` with a registered `maze_in` one cycle later. Optionally records cells the solver marks with `maze_we`. It sits between the testbench/host row loader and the maze solver, and is the only owner of maze contents.

## Interface
- `maze_width`, 6, coordinate width; maze is N×N with N = 2^maze_width
- `clk` in 1, rising-edge clock
- `rst` in 1, synchronous active-high reset
- `load_start` in 1, begins (re)loading the bitmap from row 0
- `load_valid` in 1, `load_row_bits` carries a row
- `load_row_bits` in N, wall bits of one row; bit c = column c; 1 = wall
- `load_ready` out 1, block accepts a row this cycle
- `loaded` out 1, full bitmap present; reads are served
- `row`, `col` in maze_width, cell selected by the solver
- `maze_oe` in 1, synchronous read request
- `maze_we` in 1, synchronous visit-mark request
- `maze_in` out 1, wall bit of the cell requested on the previous `maze_oe` cycle
- `visit_count` out 2·maze_width+1, number of distinct cells marked (only with `MAZE_MEM_TRACE_EN`)

## Operation
- FSM states: IDLE, LOAD, SERVE.
- IDLE (after reset): `load_ready`=0, `loaded`=0. `maze_oe` and `maze_we` are ignored. `load_start` moves the FSM to LOAD and clears the row counter.
- LOAD: `load_ready`=1. Each cycle with `load_valid`=1 writes `load_row_bits` into row `load_cnt`, then increments `load_cnt`. Acceptance of row N-1 moves the FSM to SERVE. `load_start` in LOAD resets `load_cnt` to 0, and rows already written stay until overwritten. `maze_oe` and `maze_we` are ignored.
- SERVE: `loaded`=1, `load_ready`=0. `maze_oe`=1 registers `maze_in <= wall[row][col]`. With `maze_oe`=0, `maze_in` holds its value. `maze_we` marks the cell (see Configuration). `load_start` in SERVE moves the FSM to LOAD, clears `load_cnt`, and clears all visit state.
- `maze_oe` and `maze_we` together on the same cell: `maze_in` returns the wall bit. Marking never alters wall bits.
- Coordinates always lie in range (N = 2^maze_width), so there is no bounds check.
- `load_cnt` is maze_width bits wide. Transition to SERVE is decided on `load_cnt`==N-1 with acceptance, not on wrap.

## Timing
- Reset values: state IDLE, `load_cnt`=0, `maze_in`=1 (wall, fail-safe), `load_ready`=0, `loaded`=0, `visit_count`=0, visit bitmap cleared. Wall bitmap is not reset.
- Read latency is exactly 1 cycle: request at edge k, `maze_in` valid after edge k+1. This matches a solver that drives coordinates in one state and samples in the next.
- `load_ready` and `loaded` are registered and follow the state. The first SERVE cycle is the cycle after the last row is accepted.
- A full load takes N accepted beats. With `load_valid` held high it takes N cycles.
- `rst` mid-LOAD or mid-SERVE: the next cycle is IDLE with all registered outputs at reset values.

## Configuration
- `MAZE_MEM_TRACE_EN` defined: an N×N visit bitmap is present. In SERVE, `maze_we`=1 sets visit[row][col]. `visit_count` increments only when that bit was previously 0, and saturates at N².
- Not defined: no visit bitmap. `maze_we` is ignored. `visit_count` port is absent.

## Structure
- Shared package `maze_pkg`: `MAZE_W` (6), `MAZE_N`, state enum {ST_IDLE, ST_LOAD, ST_SERVE}. The solver also uses this package.
- Sub-module `maze_bitmap`: N×N bit storage with one row-wide write port, one single-bit set port, a clear, and one registered single-bit read. It is instantiated once for walls and once for visits when `MAZE_MEM_TRACE_EN` is defined.

## Test plan
- Reset then 64 rows, with row r = 64'h1 << (r mod 64) and `load_valid` held high → `loaded` rises on cycle 65 after the first beat; `load_ready` falls the same cycle.
- Read (row 5, col 5) → `maze_in`=1 next cycle. Read (5, 6) → 0. `maze_oe` low for 3 cycles → `maze_in` holds 0.
- `maze_oe` during LOAD or IDLE → `maze_in` stays at its prior value. No write occurs on `maze_we`.
- With TRACE: `maze_we` on (1,2), (1,2), (3,4) → `visit_count`=2. Then `load_start` → `visit_count`=0.
- Simultaneous `maze_oe`+`maze_we` on wall cell (7,7) → `maze_in`=1 and the wall is unchanged on reread.
- `rst` asserted after 30 loaded rows → IDLE, `maze_in`=1, `load_ready`=0. Restart the load and the full 64-row load completes normally.
